axil_arb_2to1: RTL
==================

Name: axil_arb_2to1

Overview:
- Two-master to one-slave AXI4-Lite arbiter.
- Shares the fabric register bus (40-bit address, 32-bit data) between the PS CPU master (s0) and a second fabric master such as a debug or DMA-config engine (s1).
- One transaction in flight at a time, with round-robin grant.
- Addresses outside the decoded window are answered locally with DECERR and never reach the slave.

Parameters:
- A_W, 40, address width.
- D_W, 32, data width. Strobe width is D_W/8.
- ADDR_BASE, 40'h00_A000_0000, base of the window forwarded to m.
- ADDR_MASK, 40'hFF_F000_0000, bits compared against ADDR_BASE. Address is in window when (addr & ADDR_MASK) == ADDR_BASE.

Ports:
- aclk  input  1  bus clock.
- aresetn  input  1  asynchronous active-low reset.
- s0  axi4_if slave  A_W/D_W  requester 0 (CPU).
- s1  axi4_if slave  A_W/D_W  requester 1.
- m  axi4_if master  A_W/D_W  shared downstream slave.
- grant  output  1  index of current or last granted master.
- busy  output  1  high whenever the state is not IDLE.
- decerr_cnt  output  16  saturating count of locally answered DECERR transactions.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; grant=0; rr_ptr=0; decerr_cnt=0.
  - All s*.ready/valid outputs and m valid/ready outputs are 0.
- Request per master: req_i = awvalid_i | arvalid_i.
  - In IDLE, when only one master requests, that master wins.
  - When both request, the master at rr_ptr wins.
- Within the winning master, a write (awvalid) beats a read (arvalid).
- Arbitration latency: the grant is registered in the cycle after IDLE sees a request. No s* or m handshake occurs in the IDLE cycle.
- rr_ptr is set to the non-winning index when a transaction completes, giving strict alternation under constant contention.
- States: IDLE, WR, WR_RESP, RD, RD_RESP, ERR_WR, ERR_RD.
- IDLE -> WR, RD, ERR_WR or ERR_RD: the decode uses the granted awaddr or araddr, sampled in IDLE.
- WR:
  - m.aw* and m.w* are combinationally forwarded from the granted master.
  - The granted awready/wready mirror m.
  - AW and W complete independently; per-channel done flags stop re-forwarding after each handshake.
  - Transition to WR_RESP when both are done.
- WR_RESP:
  - m.b* is forwarded to the granted master, and m.bready mirrors the granted bready.
  - On the B handshake, go to IDLE and update rr_ptr.
- RD:
  - m.ar* is forwarded.
  - On the AR handshake, go to RD_RESP.
- RD_RESP:
  - m.r* is forwarded.
  - On the R handshake, go to IDLE.
- ERR_WR:
  - Accept AW and W locally (ready=1 until each handshake completes).
  - Then drive bvalid=1, bresp=2'b11 until bready.
  - Then increment decerr_cnt and go to IDLE.
- ERR_RD:
  - Accept AR, then drive rvalid=1, rresp=2'b11, rdata=32'hDEAD_BEEF until rready.
  - Then increment decerr_cnt and go to IDLE.
- Non-granted master: all of its ready/valid outputs are held 0. Its valids may remain high indefinitely, and its held signals are never altered.
- m valid outputs are 0 outside WR and RD. m.bready and m.rready are 0 outside WR_RESP and RD_RESP.
- arprot and awprot are forwarded unchanged.
- decerr_cnt saturates at 16'hFFFF.
- Simultaneous AW and W on the same cycle: both complete, and WR_RESP is entered the next cycle.
- W before AW and AW before W are both legal.
- Reset mid-transaction: everything returns to reset values immediately. No response is owed to either master.

Test Plan:
- s0 write addr 40'h00_A000_0010, data 32'h1234_5678 alone -> appears on m one cycle after awvalid; s0 gets bresp=0; busy pulses; grant=0.
- s0 and s1 both assert arvalid continuously for 4 reads -> m sees grant order 0,1,0,1; each requester gets its rdata; no overlap on m.
- s1 read addr 40'h00_0000_0000 (outside window) -> m.arvalid stays 0; s1 gets rresp=2'b11, rdata=32'hDEAD_BEEF; decerr_cnt=1.
- s0 drives wvalid 3 cycles before awvalid, and m holds awready low 5 cycles -> exactly one AW and one W handshake on m; s0 bresp relayed.
- Write with m.bvalid asserted while s0.bready is low for 4 cycles -> m.bready low for those cycles; s0 B handshake completes afterwards; return to IDLE.
- aresetn asserted during RD_RESP -> all outputs 0 asynchronously; state IDLE; the next s1 request is granted normally.

Source files
------------

// File: rtl/axil_arb_2to1_if.sv
// AXI4-Lite channel bundle shared by requesters and the downstream slave.
// Latency: none, wires only.
// Backpressure: plain valid/ready on each of the five channels.
// Ports: A_W-bit AW/AR addresses with 3-bit prot; D_W-bit W/R data with D_W/8 strobes; 2-bit B/R responses.
interface axi4_if #(
    parameter int A_W = 40,
    parameter int D_W = 32
);
    logic [A_W-1:0]   awaddr;
    logic [2:0]       awprot;
    logic             awvalid;
    logic             awready;
    logic [D_W-1:0]   wdata;
    logic [D_W/8-1:0] wstrb;
    logic             wvalid;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    logic [A_W-1:0]   araddr;
    logic [2:0]       arprot;
    logic             arvalid;
    logic             arready;
    logic [D_W-1:0]   rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_arb_2to1.sv
// Two-requester to one-slave AXI4-Lite arbiter, round-robin, one transaction in flight; out-of-window accesses answered locally with DECERR.
// Latency: grant registered one cycle after a request is seen in IDLE, then channels are combinationally forwarded.
// Backpressure: downstream ready/valid is passed straight through to the granted requester; the other requester sees all readies/valids low.
// Ports: aclk/aresetn; s0, s1 requester-side axi4_if.slave; m downstream axi4_if.master; grant (current/last winner), busy (not IDLE), decerr_cnt (saturating).
module axil_arb_2to1 #(
    parameter int             A_W       = 40,
    parameter int             D_W       = 32,
    parameter logic [A_W-1:0] ADDR_BASE = 40'h00_A000_0000,
    parameter logic [A_W-1:0] ADDR_MASK = 40'hFF_F000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi4_if.slave       s0,
    axi4_if.slave       s1,
    axi4_if.master      m,
    output logic        grant,
    output logic        busy,
    output logic [15:0] decerr_cnt
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_RESP, RD, RD_RESP, ERR_WR, ERR_RD
    } state_t;

    state_t state;
    logic   rr_ptr;
    logic   aw_done;
    logic   w_done;
    logic   ar_done;

    // Signals of the currently granted requester.
    logic [A_W-1:0]   g_awaddr, g_araddr;
    logic [2:0]       g_awprot, g_arprot;
    logic [D_W-1:0]   g_wdata;
    logic [D_W/8-1:0] g_wstrb;
    logic             g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    always_comb begin
        g_awaddr  = grant ? s1.awaddr  : s0.awaddr;
        g_awprot  = grant ? s1.awprot  : s0.awprot;
        g_awvalid = grant ? s1.awvalid : s0.awvalid;
        g_wdata   = grant ? s1.wdata   : s0.wdata;
        g_wstrb   = grant ? s1.wstrb   : s0.wstrb;
        g_wvalid  = grant ? s1.wvalid  : s0.wvalid;
        g_bready  = grant ? s1.bready  : s0.bready;
        g_araddr  = grant ? s1.araddr  : s0.araddr;
        g_arprot  = grant ? s1.arprot  : s0.arprot;
        g_arvalid = grant ? s1.arvalid : s0.arvalid;
        g_rready  = grant ? s1.rready  : s0.rready;
    end

    // Arbitration and address decode, only meaningful in IDLE.
    logic           req0, req1, win, win_is_wr, win_hit;
    logic [A_W-1:0] win_addr;

    always_comb begin
        req0      = s0.awvalid | s0.arvalid;
        req1      = s1.awvalid | s1.arvalid;
        win       = (req0 && req1) ? rr_ptr : req1;
        win_is_wr = win ? s1.awvalid : s0.awvalid;
        if (win_is_wr) win_addr = win ? s1.awaddr : s0.awaddr;
        else           win_addr = win ? s1.araddr : s0.araddr;
        win_hit   = (win_addr & ADDR_MASK) == ADDR_BASE;
    end

    // Downstream forwarding; done flags stop a channel being offered twice.
    logic m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;

    always_comb begin
        m_awvalid = (state == WR) && g_awvalid && !aw_done;
        m_wvalid  = (state == WR) && g_wvalid  && !w_done;
        m_arvalid = (state == RD) && g_arvalid;
        m_bready  = (state == WR_RESP) && g_bready;
        m_rready  = (state == RD_RESP) && g_rready;
    end

    assign m.awaddr  = g_awaddr;
    assign m.awprot  = g_awprot;
    assign m.awvalid = m_awvalid;
    assign m.wdata   = g_wdata;
    assign m.wstrb   = g_wstrb;
    assign m.wvalid  = m_wvalid;
    assign m.bready  = m_bready;
    assign m.araddr  = g_araddr;
    assign m.arprot  = g_arprot;
    assign m.arvalid = m_arvalid;
    assign m.rready  = m_rready;

    logic m_aw_hs, m_w_hs, m_ar_hs, m_b_hs, m_r_hs;

    always_comb begin
        m_aw_hs = m_awvalid && m.awready;
        m_w_hs  = m_wvalid  && m.wready;
        m_ar_hs = m_arvalid && m.arready;
        m_b_hs  = m_bready  && m.bvalid;
        m_r_hs  = m_rready  && m.rvalid;
    end

    // Response side toward the granted requester, before per-requester gating.
    logic           r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]     r_bresp, r_rresp;
    logic [D_W-1:0] r_rdata;

    always_comb begin
        r_awready = 1'b0;
        r_wready  = 1'b0;
        r_bvalid  = 1'b0;
        r_bresp   = 2'b00;
        r_arready = 1'b0;
        r_rvalid  = 1'b0;
        r_rresp   = 2'b00;
        r_rdata   = '0;
        case (state)
            WR: begin
                r_awready = m.awready && !aw_done;
                r_wready  = m.wready  && !w_done;
            end
            WR_RESP: begin
                r_bvalid = m.bvalid;
                r_bresp  = m.bresp;
            end
            RD: r_arready = m.arready;
            RD_RESP: begin
                r_rvalid = m.rvalid;
                r_rresp  = m.rresp;
                r_rdata  = m.rdata;
            end
            ERR_WR: begin
                r_awready = !aw_done;
                r_wready  = !w_done;
                r_bvalid  = aw_done && w_done;
                r_bresp   = 2'b11;
            end
            ERR_RD: begin
                r_arready = !ar_done;
                r_rvalid  = ar_done;
                r_rresp   = 2'b11;
                r_rdata   = D_W'(32'hDEAD_BEEF);
            end
            default: ;
        endcase
    end

    // busy mirrors state != IDLE, so it doubles as the "grant is live" qualifier.
    logic sel0, sel1;
    assign sel0 = busy && !grant;
    assign sel1 = busy && grant;

    assign s0.awready = sel0 && r_awready;
    assign s0.wready  = sel0 && r_wready;
    assign s0.bvalid  = sel0 && r_bvalid;
    assign s0.bresp   = sel0 ? r_bresp : 2'b00;
    assign s0.arready = sel0 && r_arready;
    assign s0.rvalid  = sel0 && r_rvalid;
    assign s0.rresp   = sel0 ? r_rresp : 2'b00;
    assign s0.rdata   = sel0 ? r_rdata : '0;

    assign s1.awready = sel1 && r_awready;
    assign s1.wready  = sel1 && r_wready;
    assign s1.bvalid  = sel1 && r_bvalid;
    assign s1.bresp   = sel1 ? r_bresp : 2'b00;
    assign s1.arready = sel1 && r_arready;
    assign s1.rvalid  = sel1 && r_rvalid;
    assign s1.rresp   = sel1 ? r_rresp : 2'b00;
    assign s1.rdata   = sel1 ? r_rdata : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            rr_ptr     <= 1'b0;
            busy       <= 1'b0;
            decerr_cnt <= 16'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ar_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    ar_done <= 1'b0;
                    if (req0 || req1) begin
                        grant <= win;
                        busy  <= 1'b1;
                        if (win_is_wr) state <= win_hit ? WR : ERR_WR;
                        else           state <= win_hit ? RD : ERR_RD;
                    end
                end
                WR: begin
                    if ((aw_done || m_aw_hs) && (w_done || m_w_hs)) begin
                        state   <= WR_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done || m_aw_hs;
                        w_done  <= w_done  || m_w_hs;
                    end
                end
                WR_RESP: begin
                    if (m_b_hs) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= !grant;
                    end
                end
                RD: begin
                    if (m_ar_hs) state <= RD_RESP;
                end
                RD_RESP: begin
                    if (m_r_hs) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= !grant;
                    end
                end
                ERR_WR: begin
                    if (aw_done && w_done) begin
                        if (g_bready) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= !grant;
                            if (decerr_cnt != 16'hFFFF) decerr_cnt <= decerr_cnt + 16'd1;
                        end
                    end else begin
                        if (g_awvalid) aw_done <= 1'b1;
                        if (g_wvalid)  w_done  <= 1'b1;
                    end
                end
                ERR_RD: begin
                    if (!ar_done) begin
                        if (g_arvalid) ar_done <= 1'b1;
                    end else if (g_rready) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= !grant;
                        if (decerr_cnt != 16'hFFFF) decerr_cnt <= decerr_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
